ram_bist_ctrl: RTL
==================

RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 6, RAM address width; DATA_W, default 8, RAM data width; BG, default 8'h55, background pattern ("0" = BG, "1" = ~BG).
REQ-002 Ports SHALL be as follows; the clock is clk, and rst is a synchronous, active-low reset:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-low reset.
- start  in  1  level, sampled in IDLE/DONE/FAIL.
- busy  out  1  test running.
- done  out  1  test finished (pass or fail).
- pass  out  1  valid while done=1.
- fail_addr  out  ADDR_W  address of first mismatch.
- fail_data  out  DATA_W  data read at first mismatch.
- err_cnt  out  8  mismatch count.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM write data.
- ram_dout  in  DATA_W  RAM read data, valid one cycle after a read address.

Function
REQ-003 The block SHALL act as initiator for a single-port RAM with 1-cycle registered read, running March C- reduced: M0 up W0; M1 up R0,W1; M2 down R1,W0; M3 up R0.
REQ-004 FSM states SHALL be IDLE, M0, M1_RD, M1_CMP, M2_RD, M2_CMP, M3_RD, M3_CMP, DONE, FAIL.
REQ-005 IDLE/DONE/FAIL: start=1 SHALL enter M0 with addr=0 next cycle, clearing done, pass, fail_addr, fail_data and err_cnt.
REQ-006 M0 SHALL drive ram_we=1 and ram_din=BG, one address per cycle, 0 to 2^ADDR_W-1, then enter M1_RD at addr 0.
REQ-007 *_RD states SHALL drive ram_we=0 with the current address.
REQ-008 *_CMP states SHALL compare ram_dout with the expected value (M1/M3: BG; M2: ~BG) on the same address.
REQ-009 In M1_CMP and M2_CMP the block SHALL drive ram_we=1 with ram_din=~BG (M1) or BG (M2) in the same cycle.
REQ-010 Address order SHALL be ascending for M1 and M3, and descending from 2^ADDR_W-1 to 0 for M2; the terminal address SHALL advance to the next element (M3 terminal goes to DONE).
REQ-011 A fault-free run SHALL assert done exactly 7*2^ADDR_W+1 cycles after start is sampled (449 for defaults).
REQ-012 busy SHALL be 1 exactly in the M0 to M3_CMP states; done=1 only in DONE/FAIL; pass=1 only in DONE with err_cnt=0.
REQ-013 start while busy SHALL be ignored.
REQ-014 ram_we SHALL be 0 in IDLE, DONE, FAIL and all *_RD states.
REQ-015 Only the first mismatch SHALL load fail_addr/fail_data; these SHALL hold until the next start.

Reset
REQ-016 When rst=0 at a clock edge, the next state SHALL be IDLE with all outputs 0 (ram_we=0, ram_addr=0, ram_din=0, flags 0, err_cnt=0), including when the test is mid-run.
REQ-017 After reset the block SHALL issue no RAM write until start is sampled.

Configuration
REQ-018 With macro RAM_BIST_ERR_CNT_EN defined, a mismatch SHALL increment err_cnt (saturating at 255), the test SHALL continue to completion, and the end state SHALL be DONE with pass=(err_cnt==0).
REQ-019 Without RAM_BIST_ERR_CNT_EN, the first mismatch SHALL enter FAIL next cycle (done=1, pass=0, ram_we=0), err_cnt SHALL be 1 after a failure and 0 otherwise, and the pending write in that CMP cycle SHALL still be issued.

Structure
REQ-020 Package ram_bist_pkg SHALL hold ADDR_W/DATA_W defaults, the BG default, and the state enum localparams.
REQ-021 Sub-module ram_bist_addr_gen SHALL hold the up/down address counter with load-to-start and terminal-count flag; the FSM and compare logic stay in ram_bist_ctrl.

Verification
REQ-022 The bench SHALL connect ram_bist_ctrl to a 64x8 registered-read RAM model.
- Fault-free: rst low 10 cycles, start=1 -> done at cycle 449, pass=1, err_cnt=0, RAM all 8'h55 at end.
- Stuck-at bit0=1 at addr 6 (reads 8'h55 OK, writes 8'hAA reads 8'hAB): without the macro -> FAIL in M2, fail_addr=6, fail_data=8'hAB; with the macro -> DONE, pass=0, err_cnt=1.
- Stuck-at-0 whole byte at addr 3 (always reads 8'h00), macro on -> err_cnt=3, fail_addr=3, fail_data=8'h00.
- Reset mid-run (rst=0 at cycle 200, during M2) -> next cycle IDLE with busy=0 and ram_we=0; a new start completes normally in 449 cycles.
- start held high throughout the run -> no restart while busy; from DONE, a second run starts the cycle after DONE.
- Protocol check every cycle: ram_we=0 in *_RD states; address sequence is monotonic per element (M2 descending 63 to 0).

Source files
------------

// File: rtl/ram_bist_pkg.sv
// Shared defaults, state encoding and helpers for the March C- RAM BIST controller.
package ram_bist_pkg;

  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned DATA_W_DEF = 8;
  localparam logic [7:0]  BG_DEF     = 8'h55;
  localparam int unsigned ERR_W      = 8;

  typedef enum logic [3:0] {
    IDLE,
    M0,
    M1_RD,
    M1_CMP,
    M2_RD,
    M2_CMP,
    M3_RD,
    M3_CMP,
    DONE,
    FAIL
  } state_e;

  // True for every state in which the march is actively running.
  function automatic logic is_running(input state_e s);
    return (s inside {M0, M1_RD, M1_CMP, M2_RD, M2_CMP, M3_RD, M3_CMP});
  endfunction

  // True for the read-compare cycles that sample ram_dout.
  function automatic logic is_cmp(input state_e s);
    return (s inside {M1_CMP, M2_CMP, M3_CMP});
  endfunction

endpackage

// File: rtl/ram_bist_addr_gen.sv
// Up/down RAM address counter with load-to-start (bottom or top) and terminal-count flag.
module ram_bist_addr_gen
  import ram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              load_top,
  input  logic              step,
  input  logic              down,
  output logic [ADDR_W-1:0] addr,
  output logic              last_c
);

  localparam logic [ADDR_W-1:0] TOP = '1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_top ? TOP : '0;
    end else if (step) begin
      addr <= down ? (addr - ADDR_W'(1)) : (addr + ADDR_W'(1));
    end
  end

  // Terminal address depends on the direction of the element being walked.
  assign last_c = down ? (addr == '0) : (addr == TOP);

endmodule

// File: rtl/ram_bist_ctrl.sv
// March C- reduced BIST initiator for a single-port RAM with 1-cycle registered read.
// Optional macro RAM_BIST_ERR_CNT_EN: count mismatches and run to completion instead of stopping.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int unsigned        ADDR_W = ADDR_W_DEF,
  parameter int unsigned        DATA_W = DATA_W_DEF,
  parameter logic [DATA_W-1:0]  BG     = DATA_W'(BG_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  state_e              state, state_n;
  logic                busy_n, done_n, pass_n, we_n;
  logic [DATA_W-1:0]   din_n;
  logic [ADDR_W-1:0]   fail_addr_n;
  logic [DATA_W-1:0]   fail_data_n;
  logic [ERR_W-1:0]    err_cnt_n;
  logic [DATA_W-1:0]   exp_data;
  logic                mismatch;
  logic                ag_load, ag_load_top, ag_step, ag_down, ag_last_c;

  ram_bist_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (ag_load),
    .load_top (ag_load_top),
    .step     (ag_step),
    .down     (ag_down),
    .addr     (ram_addr),
    .last_c   (ag_last_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      ram_we    <= 1'b0;
      ram_din   <= '0;
      fail_addr <= '0;
      fail_data <= '0;
      err_cnt   <= '0;
    end else begin
      state     <= state_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
      ram_we    <= we_n;
      ram_din   <= din_n;
      fail_addr <= fail_addr_n;
      fail_data <= fail_data_n;
      err_cnt   <= err_cnt_n;
    end
  end

  // Next state, address control, compare and next-cycle output values.
  always_comb begin
    state_n     = state;
    ag_load     = 1'b0;
    ag_load_top = 1'b0;
    ag_step     = 1'b0;
    ag_down     = (state == M2_RD) || (state == M2_CMP);
    fail_addr_n = fail_addr;
    fail_data_n = fail_data;
    err_cnt_n   = err_cnt;
    exp_data    = (state == M2_CMP) ? ~BG : BG;
    mismatch    = is_cmp(state) && (ram_dout != exp_data);
    busy_n      = 1'b0;
    done_n      = 1'b0;
    pass_n      = 1'b0;
    we_n        = 1'b0;
    din_n       = '0;

    case (state)
      IDLE, DONE, FAIL: begin
        if (start) begin
          state_n     = M0;
          ag_load     = 1'b1;
          fail_addr_n = '0;
          fail_data_n = '0;
          err_cnt_n   = '0;
        end
      end
      M0: begin
        if (ag_last_c) begin
          state_n = M1_RD;
          ag_load = 1'b1;
        end else begin
          ag_step = 1'b1;
        end
      end
      M1_RD: state_n = M1_CMP;
      M1_CMP: begin
        if (ag_last_c) begin
          state_n     = M2_RD;
          ag_load     = 1'b1;
          ag_load_top = 1'b1;
        end else begin
          state_n = M1_RD;
          ag_step = 1'b1;
        end
      end
      M2_RD: state_n = M2_CMP;
      M2_CMP: begin
        if (ag_last_c) begin
          state_n = M3_RD;
          ag_load = 1'b1;
        end else begin
          state_n = M2_RD;
          ag_step = 1'b1;
        end
      end
      M3_RD: state_n = M3_CMP;
      M3_CMP: begin
        if (ag_last_c) begin
          state_n = DONE;
          ag_load = 1'b1;
        end else begin
          state_n = M3_RD;
          ag_step = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // A zero error count means this is the first mismatch of the run.
    if (mismatch) begin
      if (err_cnt == '0) begin
        fail_addr_n = ram_addr;
        fail_data_n = ram_dout;
      end
`ifdef RAM_BIST_ERR_CNT_EN
      if (err_cnt != '1) begin
        err_cnt_n = err_cnt + ERR_W'(1);
      end
`else
      err_cnt_n   = ERR_W'(1);
      state_n     = FAIL;
      ag_load     = 1'b1;
      ag_load_top = 1'b0;
      ag_step     = 1'b0;
`endif
    end

    busy_n = is_running(state_n);
    done_n = (state_n == DONE) || (state_n == FAIL);
    pass_n = (state_n == DONE) && (err_cnt_n == '0);
    we_n   = (state_n == M0) || (state_n == M1_CMP) || (state_n == M2_CMP);
    case (state_n)
      M0:      din_n = BG;
      M1_CMP:  din_n = ~BG;
      M2_CMP:  din_n = BG;
      default: din_n = '0;
    endcase
  end

endmodule
